// File: rtl/mem_port_arbiter.sv
// Purpose : round-robin arbiter/sequencer giving two CPU ports access to a single-ported 256-word RAM.
// Latency : req sampled in IDLE at edge n -> gnt + RAM strobe in cycle n+1 -> done + rdata in cycle n+2.
// Backpres: requests are held until done; a losing or late port waits in place, 1 transaction per 3 cycles.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   pX_req/we/addr/wdata       port X request (held until pX_done), direction, address, write data
//   pX_gnt, pX_done            port X owns the ACCESS cycle / one-cycle completion pulse
//   rdata                      last read data, valid with done of a read, held afterwards
//   ram_addr/wdata/we/re       RAM control, driven only in the ACCESS cycle (addr/wdata hold otherwise)
//   ram_rdata                  combinational RAM read data
//   busy, xact_count           FSM not IDLE / completed transactions (wrapping 16-bit)
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic [15:0]       xact_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              owner;
  logic              last_owner;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  // Grant selection for the IDLE cycle: a lone requester wins, a tie goes
  // to the port that did not complete the previous transaction.
  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    pick      = p1_req & (~p0_req | ~last_owner);
    sel_we    = pick ? p1_we    : p0_we;
    sel_addr  = pick ? p1_addr  : p0_addr;
    sel_wdata = pick ? p1_wdata : p0_wdata;
  end

  // The latched request drives the RAM bus directly, so address and data
  // naturally hold their last values outside ACCESS.
  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata      <= '0;
      p0_gnt     <= 1'b0;
      p1_gnt     <= 1'b0;
      p0_done    <= 1'b0;
      p1_done    <= 1'b0;
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
      busy       <= 1'b0;
      xact_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            owner     <= pick;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            p0_gnt    <= ~pick;
            p1_gnt    <= pick;
            // Strobes are registered here so they are exclusive by construction.
            ram_we    <= sel_we;
            ram_re    <= ~sel_we;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // RAM read is combinational: data is valid at the end of ACCESS.
          if (!lat_we) begin
            rdata <= ram_rdata;
          end
          p0_gnt  <= 1'b0;
          p1_gnt  <= 1'b0;
          ram_we  <= 1'b0;
          ram_re  <= 1'b0;
          p0_done <= ~owner;
          p1_done <= owner;
          state   <= RESP;
        end
        RESP: begin
          p0_done    <= 1'b0;
          p1_done    <= 1'b0;
          last_owner <= owner;
          xact_count <= xact_count + 16'd1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 256x32 combinational-read RAM.
// Inputs are driven and outputs sampled at the falling edge, away from the active edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [7:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p0_done, p1_gnt, p1_done;
  logic [31:0] rdata;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we, ram_re;
  logic [31:0] ram_rdata;
  logic        busy;
  logic [15:0] xact_count;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_gnt    (p0_gnt),
    .p0_done   (p0_done),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_gnt    (p1_gnt),
    .p1_done   (p1_done),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .xact_count(xact_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: preloaded while reset is held, written on the edge with we high.
  logic [31:0] mem [256];
  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10] <= 32'hDEADBEEF;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int g_port [8];
  int g_cyc  [8];
  int d_cyc  [8];
  int ng, nd, both_strobe, extra_gnt;
  logic [31:0] exp_rd;

  initial begin
    reset = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_p1_gnt", p1_gnt, 0);
    chk("rst_p0_done", p0_done, 0);
    chk("rst_p1_done", p1_done, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_re", ram_re, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", xact_count, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single read by p0 of 0x10
    p0_req = 1; p0_we = 0; p0_addr = 8'h10;
    @(negedge clk);
    chk("rd_p0_gnt", p0_gnt, 1);
    chk("rd_p1_gnt", p1_gnt, 0);
    chk("rd_ram_re", ram_re, 1);
    chk("rd_ram_we", ram_we, 0);
    chk("rd_ram_addr", ram_addr, 32'h10);
    chk("rd_busy_access", busy, 1);
    @(negedge clk);
    chk("rd_p0_done", p0_done, 1);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    chk("rd_gnt_dropped", p0_gnt, 0);
    chk("rd_re_dropped", ram_re, 0);
    chk("rd_busy_resp", busy, 1);
    p0_req = 0;
    @(negedge clk);
    chk("rd_count", xact_count, 1);
    chk("rd_busy_idle", busy, 0);
    chk("rd_done_pulse", p0_done, 0);

    // p1 writes 0xFF then reads it back
    p1_req = 1; p1_we = 1; p1_addr = 8'hFF; p1_wdata = 32'h12345678;
    @(negedge clk);
    chk("wr_p1_gnt", p1_gnt, 1);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_re", ram_re, 0);
    chk("wr_ram_addr", ram_addr, 32'hFF);
    chk("wr_ram_wdata", ram_wdata, 32'h12345678);
    @(negedge clk);
    chk("wr_we_one_cycle", ram_we, 0);
    chk("wr_p1_done", p1_done, 1);
    chk("wr_rdata_kept", rdata, 32'hDEADBEEF);
    p1_req = 0;
    @(negedge clk);
    chk("wr_mem", mem[8'hFF], 32'h12345678);
    chk("wr_count", xact_count, 2);
    p1_req = 1; p1_we = 0;
    @(negedge clk);
    chk("rb_ram_re", ram_re, 1);
    @(negedge clk);
    chk("rb_p1_done", p1_done, 1);
    chk("rb_rdata", rdata, 32'h12345678);
    p1_req = 0;
    @(negedge clk);
    chk("rb_count", xact_count, 3);

    // Tie: both ports request continuously for four transactions
    p0_req = 1; p0_we = 0; p0_addr = 8'h10;
    p1_req = 1; p1_we = 0; p1_addr = 8'hFF;
    ng = 0; nd = 0; both_strobe = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ram_we && ram_re) both_strobe++;
      if ((p0_gnt || p1_gnt) && ng < 8) begin
        g_port[ng] = p1_gnt ? 1 : 0;
        g_cyc[ng]  = c;
        ng++;
      end
      if ((p0_done || p1_done) && nd < 8) begin
        exp_rd = p1_done ? 32'h12345678 : 32'hDEADBEEF;
        chk("tie_rdata", rdata, exp_rd);
        d_cyc[nd] = c;
        nd++;
      end
      if (c == 11) begin
        p0_req = 0;
        p1_req = 0;
      end
    end
    chk("tie_num_gnt", ng, 4);
    chk("tie_num_done", nd, 4);
    for (int k = 0; k < 4; k++) begin
      chk("tie_order", g_port[k], k % 2);
      chk("tie_gnt_cycle", g_cyc[k], 1 + 3 * k);
      chk("tie_done_cycle", d_cyc[k], 2 + 3 * k);
    end
    chk("tie_we_re_excl", both_strobe, 0);
    chk("tie_count", xact_count, 7);
    chk("tie_busy_idle", busy, 0);

    // p1 drops req in ACCESS; inputs changed after grant must not matter
    p1_req = 1; p1_we = 0; p1_addr = 8'h10;
    @(negedge clk);
    chk("drop_p1_gnt", p1_gnt, 1);
    p1_req = 0; p1_addr = 8'h00;
    #1;
    chk("drop_latched_addr", ram_addr, 32'h10);
    @(negedge clk);
    chk("drop_p1_done", p1_done, 1);
    chk("drop_rdata", rdata, 32'hDEADBEEF);
    extra_gnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (p1_gnt || p0_gnt) extra_gnt++;
    end
    chk("drop_no_regrant", extra_gnt, 0);
    chk("drop_count", xact_count, 8);

    // Asynchronous reset during ACCESS
    p0_req = 1; p0_we = 0; p0_addr = 8'h10;
    p1_req = 1; p1_we = 0; p1_addr = 8'hFF;
    @(negedge clk);
    chk("mrst_pre_p0_gnt", p0_gnt, 1);
    #2 reset = 1'b1;
    #1;
    chk("mrst_p0_gnt", p0_gnt, 0);
    chk("mrst_ram_re", ram_re, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_count", xact_count, 0);
    chk("mrst_rdata", rdata, 0);
    chk("mrst_ram_addr", ram_addr, 0);
    @(negedge clk);
    chk("mrst_no_done", p0_done, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_tie_p0", p0_gnt, 1);
    chk("mrst_tie_p1", p1_gnt, 0);
    p1_req = 0;
    @(negedge clk);
    chk("mrst_p0_done", p0_done, 1);
    chk("mrst_rdata_after", rdata, 32'hDEADBEEF);
    p0_req = 0;
    @(negedge clk);
    chk("mrst_count_after", xact_count, 1);

    // Counter wrap from 0xFFFF, using a write so rdata must stay put
    force dut.xact_count = 16'hFFFF;
    #1 release dut.xact_count;
    #1;
    chk("wrap_preload", xact_count, 32'hFFFF);
    p0_req = 1; p0_we = 1; p0_addr = 8'h20; p0_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("wrap_ram_we", ram_we, 1);
    @(negedge clk);
    chk("wrap_rdata_kept", rdata, 32'hDEADBEEF);
    chk("wrap_before", xact_count, 32'hFFFF);
    p0_req = 0;
    @(negedge clk);
    chk("wrap_after", xact_count, 0);
    chk("wrap_mem", mem[8'h20], 32'hA5A5A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter and sequencer for the CPU's single-ported 256-word RAM. It accepts memory requests from the instruction-fetch port (port 0) and the load/store port (port 1), grants them round-robin, and drives the RAM's address, data_in, we and re lines for exactly one cycle per transaction. It captures read data into a register and returns it with a one-cycle done pulse. It sits between the CPU control unit/datapath and the ram block; it is the only driver of the RAM control lines.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 32, data word width

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- p0_req  in  1  fetch port request; held until p0_done
- p0_we  in  1  fetch port write (1) / read (0)
- p0_addr  in  ADDR_W  fetch port address
- p0_wdata  in  DATA_W  fetch port write data
- p0_gnt  out  1  fetch port granted (ACCESS cycle)
- p0_done  out  1  fetch transaction complete, one-cycle pulse
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done  same as p0, load/store port
- rdata  out  DATA_W  registered read data, valid while pX_done=1 for a read, held afterwards
- ram_addr  out  ADDR_W  to RAM address
- ram_wdata  out  DATA_W  to RAM data_in
- ram_we  out  1  to RAM write enable
- ram_re  out  1  to RAM read enable
- ram_rdata  in  DATA_W  from RAM data_out
- busy  out  1  FSM not IDLE
- xact_count  out  16  completed transactions, wraps at 0xFFFF -> 0

## Operation
- FSM states are IDLE, ACCESS and RESP. State, the owner register and last_owner are registered.
- IDLE: if no request, stay. If one request, grant that port. If both, grant the port that is not last_owner. Latch owner, we, addr and wdata into internal registers, then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - ram_addr and ram_wdata come from the latched registers.
  - ram_we = latched we; ram_re = ~latched we.
  - pX_gnt=1 for the owner.
  - At the clock edge, rdata <= ram_rdata if the transaction is a read. Then go to RESP.
- RESP (exactly 1 cycle):
  - pX_done=1 for the owner.
  - last_owner <= owner; xact_count += 1.
  - RAM lines are idle.
  - Next state is IDLE.
- In IDLE and RESP, RAM outputs are ram_we=0 and ram_re=0. ram_addr and ram_wdata hold their last values.
- ram_we and ram_re are never both 1.
- Requests are sampled only in IDLE. Inputs may change after grant; the latched copies are used.
- If the owner drops req during ACCESS or RESP, the transaction still completes and done still pulses.
- A write leaves rdata unchanged.
- Other-port requests arriving mid-transaction wait. With both ports requesting continuously, grants alternate 0,1,0,1…

## Timing
- Reset (asynchronous, any state) forces:
  - state=IDLE
  - all gnt/done=0, ram_we=ram_re=0
  - ram_addr=0, ram_wdata=0, rdata=0
  - xact_count=0, busy=0
  - last_owner=1, so port 0 wins the first tie.
- Reset during ACCESS aborts the transaction and no done is issued. A write whose enable was already high may or may not have landed.
- Latency: req sampled high in IDLE at edge n → ACCESS in cycle n+1 → done (and rdata valid) in cycle n+2.
- Back-to-back throughput is one transaction per 3 cycles. The next grant is decided in the IDLE cycle following RESP.
- busy=1 in ACCESS and RESP only.
- The RAM is combinational-read, so ram_rdata is sampled at the end of the ACCESS cycle with re high.

## Test plan
- Reset mid-stream: assert reset during ACCESS → all outputs 0 immediately (asynchronous). After release, p0 is granted before p1 on a tie.
- Single read: preload RAM[0x10]=0xDEADBEEF; p0 reads 0x10 → p0_gnt in cycle n+1 with ram_re=1, ram_addr=0x10; p0_done with rdata=0xDEADBEEF in cycle n+2; xact_count=1.
- Write then read: p1 writes 0x12345678 to 0xFF, then reads 0xFF → ram_we=1 for exactly one cycle; rdata=0x12345678 on the second done; rdata unchanged after the write.
- Tie arbitration: p0 and p1 both request continuously for 4 transactions → grant order 0,1,0,1; dones 3 cycles apart; ram_we and ram_re never both 1.
- Req dropped: p1 deasserts req in the ACCESS cycle → p1_done still pulses in RESP; no second grant to p1.
- Counter wrap: force 65536 transactions (or preload the counter) → xact_count goes 0xFFFF → 0x0000.
